// File: rtl/spi_pkg.sv
// spi_pkg: shared types and defaults for the SPI flash read path.
//   state_e  - transaction FSM states of spi_flash_reader
//   phase_e  - per-byte handshake phases of spi_byte_xfer
//   CMD_READ_DEFAULT, DUMMY_BYTE, TIMEOUT_CYCLES_DEFAULT - default constants
package spi_pkg;

   typedef enum logic [3:0] {
      StIdle,
      StCmd,
      StA2,
      StA1,
      StA0,
      StData,
      StHold,
      StCsEnd,
      StDone
   } state_e;

   typedef enum logic [1:0] {
      PhIdle,
      PhIssue,
      PhWait
   } phase_e;

   localparam logic [7:0]  CMD_READ_DEFAULT       = 8'h03;
   localparam logic [7:0]  DUMMY_BYTE             = 8'h00;
   localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 64;

endpackage

// File: rtl/spi_byte_xfer.sv
// spi_byte_xfer: one byte exchange with the SPI controller, with a watchdog.
//   clk, reset        - system clock, synchronous active-high reset
//   i_go, i_tx_byte   - start a transfer (accepted only when idle) and the byte to send
//   o_spi_valid       - high during ISSUE until the controller drops spiReady
//   o_spi_data_tx     - byte presented to the controller
//   i_spi_ready       - controller idle (high) / shifting (low)
//   i_spi_data_rx     - received byte, valid when spiReady rises
//   o_rx_byte         - received byte, meaningful while o_xfer_done is high
//   o_xfer_done       - one-cycle pulse when spiReady rises in WAIT
//   o_timeout         - one-cycle pulse when a phase has lasted TIMEOUT_CYCLES cycles
module spi_byte_xfer
   import spi_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_go,
   input  logic [7:0] i_tx_byte,
   output logic       o_spi_valid,
   output logic [7:0] o_spi_data_tx,
   input  logic       i_spi_ready,
   input  logic [7:0] i_spi_data_rx,
   output logic [7:0] o_rx_byte,
   output logic       o_xfer_done,
   output logic       o_timeout
);

   localparam int unsigned     CntW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

   phase_e          r_phase, w_phase_next;
   logic [CntW-1:0] r_cnt, w_cnt_next;
   logic [7:0]      r_tx, w_tx_next;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_phase <= PhIdle;
         r_cnt   <= '0;
         r_tx    <= '0;
      end else begin
         r_phase <= w_phase_next;
         r_cnt   <= w_cnt_next;
         r_tx    <= w_tx_next;
      end
   end

   always_comb begin
      w_phase_next = r_phase;
      w_cnt_next   = r_cnt;
      w_tx_next    = r_tx;
      o_xfer_done  = 1'b0;
      o_timeout    = 1'b0;
      unique case (r_phase)
         PhIdle: begin
            if (i_go) begin
               w_phase_next = PhIssue;
               w_cnt_next   = '0;
               w_tx_next    = i_tx_byte;
            end
         end
         PhIssue: begin
            if (!i_spi_ready) begin
               w_phase_next = PhWait;
               w_cnt_next   = '0;
            end else if (r_cnt == CntLast) begin
               o_timeout    = 1'b1;
               w_phase_next = PhIdle;
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
         PhWait: begin
            if (i_spi_ready) begin
               o_xfer_done  = 1'b1;
               w_phase_next = PhIdle;
            end else if (r_cnt == CntLast) begin
               o_timeout    = 1'b1;
               w_phase_next = PhIdle;
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
         default: w_phase_next = PhIdle;
      endcase
   end

   assign o_spi_valid   = (r_phase == PhIssue);
   assign o_spi_data_tx = r_tx;
   assign o_rx_byte     = i_spi_data_rx;

endmodule

// File: rtl/spi_flash_reader.sv
// spi_flash_reader: issues READ + 24-bit address to a SPI flash and streams len bytes out.
//   clk, reset                 - system clock, synchronous active-high reset
//   i_start, i_addr, i_len     - read request, captured in IDLE only
//   o_busy, o_done, o_error    - not idle / end-of-transaction pulse / sticky timeout
//   o_rd_data, o_rd_valid,
//   i_rd_ready                 - received data stream with backpressure
//   o_cs_n                     - flash chip select, active-low
//   o_spi_data_tx, o_spi_valid,
//   i_spi_ready, i_spi_data_rx - byte-level SPI controller handshake
module spi_flash_reader
   import spi_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
   parameter logic [7:0]  CMD_READ       = CMD_READ_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_start,
   input  logic [23:0] i_addr,
   input  logic [15:0] i_len,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_error,
   output logic [7:0]  o_rd_data,
   output logic        o_rd_valid,
   input  logic        i_rd_ready,
   output logic        o_cs_n,
   output logic [7:0]  o_spi_data_tx,
   output logic        o_spi_valid,
   input  logic        i_spi_ready,
   input  logic [7:0]  i_spi_data_rx
);

   state_e      r_state, w_state_next;
   logic [23:0] r_addr, w_addr_next;
   logic [15:0] r_count, w_count_next;
   logic        r_error, w_error_next;
   logic [7:0]  r_rd_data, w_rd_data_next;
   logic        r_rd_valid, w_rd_valid_next;
   logic        r_csend, w_csend_next;

   logic        w_go;
   logic [7:0]  w_tx_byte;
   logic [7:0]  w_rx_byte;
   logic        w_xfer_done;
   logic        w_timeout;

   spi_byte_xfer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_xfer (
      .clk          (clk),
      .reset        (reset),
      .i_go         (w_go),
      .i_tx_byte    (w_tx_byte),
      .o_spi_valid  (o_spi_valid),
      .o_spi_data_tx(o_spi_data_tx),
      .i_spi_ready  (i_spi_ready),
      .i_spi_data_rx(i_spi_data_rx),
      .o_rx_byte    (w_rx_byte),
      .o_xfer_done  (w_xfer_done),
      .o_timeout    (w_timeout)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= StIdle;
         r_addr     <= '0;
         r_count    <= '0;
         r_error    <= 1'b0;
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
         r_csend    <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_addr     <= w_addr_next;
         r_count    <= w_count_next;
         r_error    <= w_error_next;
         r_rd_data  <= w_rd_data_next;
         r_rd_valid <= w_rd_valid_next;
         r_csend    <= w_csend_next;
      end
   end

   // The byte engine only accepts go while idle, so holding go high in a byte
   // state launches exactly one transfer per state visit.
   always_comb begin
      w_state_next    = r_state;
      w_addr_next     = r_addr;
      w_count_next    = r_count;
      w_error_next    = r_error;
      w_rd_data_next  = r_rd_data;
      w_rd_valid_next = r_rd_valid;
      w_csend_next    = r_csend;
      w_go            = 1'b0;
      w_tx_byte       = DUMMY_BYTE;
      unique case (r_state)
         StIdle: begin
            if (i_start) begin
               w_addr_next  = i_addr;
               w_count_next = i_len;
               w_error_next = 1'b0;
               w_state_next = StCmd;
            end
         end
         StCmd: begin
            w_go      = 1'b1;
            w_tx_byte = CMD_READ;
            if (w_xfer_done) w_state_next = StA2;
         end
         StA2: begin
            w_go      = 1'b1;
            w_tx_byte = r_addr[23:16];
            if (w_xfer_done) w_state_next = StA1;
         end
         StA1: begin
            w_go      = 1'b1;
            w_tx_byte = r_addr[15:8];
            if (w_xfer_done) w_state_next = StA0;
         end
         StA0: begin
            w_go      = 1'b1;
            w_tx_byte = r_addr[7:0];
            if (w_xfer_done) w_state_next = (r_count == '0) ? StCsEnd : StData;
         end
         StData: begin
            w_go = 1'b1;
            if (w_xfer_done) begin
               w_rd_data_next  = w_rx_byte;
               w_rd_valid_next = 1'b1;
               w_state_next    = StHold;
            end
         end
         StHold: begin
            if (r_rd_valid && i_rd_ready) begin
               w_rd_valid_next = 1'b0;
               w_count_next    = r_count - 1'b1;
               w_state_next    = (r_count != 16'd1) ? StData : StCsEnd;
            end
         end
         StCsEnd: begin
            // Two cycles with chip select released before signalling done.
            w_csend_next = ~r_csend;
            if (r_csend) w_state_next = StDone;
         end
         StDone: w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase

      if (w_timeout) begin
         w_error_next = 1'b1;
         w_count_next = '0;
         w_state_next = StCsEnd;
      end
   end

   assign o_busy     = (r_state != StIdle);
   assign o_done     = (r_state == StDone);
   assign o_error    = r_error;
   assign o_rd_data  = r_rd_data;
   assign o_rd_valid = r_rd_valid;
   assign o_cs_n     = !(r_state inside {StCmd, StA2, StA1, StA0, StData, StHold});

endmodule

// File: doc/spi_flash_reader.md
SPI_FLASH_READER -- requirements
Module: spi_flash_reader

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 64: maximum cycles spent waiting on any spiReady edge.
REQ-002 The block SHALL have parameter CMD_READ, default 8'h03: the flash read opcode.
REQ-003 The clock SHALL be clk, input, 1 bit, rising-edge system clock.
REQ-004 The reset SHALL be reset, input, 1 bit, synchronous, active-high.
REQ-005 start SHALL be an input, 1 bit: request a read; sampled in IDLE only.
REQ-006 addr SHALL be an input, 24 bits: flash byte address, captured on accepted start.
REQ-007 len SHALL be an input, 16 bits: byte count, captured on accepted start; 0 means command and address only.
REQ-008 busy SHALL be an output, 1 bit: high in every state except IDLE.
REQ-009 done SHALL be an output, 1 bit: one-cycle pulse at end of transaction.
REQ-010 error SHALL be an output, 1 bit: sticky timeout flag, cleared by the next accepted start.
REQ-011 rdData SHALL be an output, 8 bits: received data byte.
REQ-012 rdValid SHALL be an output, 1 bit: rdData is valid.
REQ-013 rdReady SHALL be an input, 1 bit: downstream accepts rdData.
REQ-014 csN SHALL be an output, 1 bit: flash chip select, active-low.
REQ-015 spiDataTx SHALL be an output, 8 bits: byte to the SPI controller.
REQ-016 spiValid SHALL be an output, 1 bit: spiDataTx is valid.
REQ-017 spiReady SHALL be an input, 1 bit: the SPI controller is idle (high) or shifting (low).
REQ-018 spiDataRx SHALL be an input, 8 bits: byte received by the SPI controller, valid when spiReady rises.

Function
REQ-019 States SHALL be IDLE, CMD, A2, A1, A0, DATA, HOLD, CSEND, DONE.
REQ-020 In IDLE, start=1 SHALL capture addr and len, clear error, drive csN=0, and move to CMD on the next cycle.
REQ-021 Each byte transfer SHALL run in two phases:
  - ISSUE: spiValid=1 until spiReady=0 is seen.
  - WAIT: spiValid=0 until spiReady=1 is seen, then spiDataRx is sampled.
REQ-022 spiDataTx SHALL be CMD_READ in CMD, addr[23:16] in A2, addr[15:8] in A1, addr[7:0] in A0, and 8'h00 in DATA.
REQ-023 Bytes received in CMD and A2..A0 SHALL be discarded.
REQ-024 After A0, the FSM SHALL go to CSEND if len==0, else to DATA.
REQ-025 At the end of the DATA WAIT phase, rdData SHALL take spiDataRx, rdValid SHALL be set, and the state SHALL go to HOLD.
REQ-026 In HOLD with rdValid && rdReady:
  - rdValid SHALL clear and the remaining count SHALL decrement.
  - The next state SHALL be DATA if the count is non-zero, else CSEND.
REQ-027 No new SPI byte SHALL be issued while rdValid=1 (backpressure); csN SHALL stay low throughout.
REQ-028 In CSEND, csN SHALL be 1 for 2 cycles, then the FSM SHALL enter DONE.
REQ-029 DONE SHALL pulse done=1 for 1 cycle, then return to IDLE.
REQ-030 A timeout counter SHALL reset on each phase entry; on reaching TIMEOUT_CYCLES it SHALL set error, drop spiValid, discard the remaining count, and go to CSEND.
REQ-031 start while busy=1 SHALL be ignored.
REQ-032 addr/len changes after capture SHALL have no effect.
REQ-033 The remaining count SHALL be 16-bit unsigned; len=16'hFFFF SHALL transfer 65535 bytes with no wrap.
REQ-034 start and the last-byte rdReady arriving in the same cycle SHALL NOT start a new transaction, because the block is not in IDLE.

Reset
REQ-035 On reset=1 (synchronous), including mid-transaction, at the next clk edge the outputs SHALL be: state=IDLE, csN=1, spiValid=0, spiDataTx=0, rdValid=0, rdData=0, busy=0, done=0, error=0, counters=0.
REQ-036 After reset, no partial byte SHALL be delivered to rdData.

Structure
REQ-037 The shared package spi_pkg SHALL hold the state enum, CMD_READ default, DUMMY_BYTE=8'h00, and the TIMEOUT_CYCLES default.
REQ-038 The ISSUE/WAIT handshake and timeout SHALL be a sub-module spi_byte_xfer (go, txByte -> spiValid/spiDataTx, rxByte, xferDone, timeout), instantiated once.

Verification
REQ-039 Single read: addr=24'h012345, len=1, bench controller model returns 8'hDE in the data slot; the bench SHALL see MOSI bytes 03,01,23,45,00, rdData=8'hDE, and one done pulse with csN returning high.
REQ-040 Burst with backpressure: len=4, rdReady low for 5 cycles per byte, model bytes AA,BB,CC,DD; the bench SHALL see all four delivered in order, spiValid=0 throughout each stall, and csN low throughout.
REQ-041 Zero length: len=0; the bench SHALL see exactly 4 SPI bytes, rdValid never asserted, and done asserted.
REQ-042 Timeout: the model holds spiReady=1 forever; the bench SHALL see error=1 after 64 cycles in CMD ISSUE, then csN high and done pulsing.
REQ-043 Reset mid-burst: reset asserted during the DATA WAIT phase of byte 2 of len=4; the bench SHALL see csN=1, spiValid=0, rdValid=0 the next cycle, and a subsequent start completing normally.
REQ-044 Start while busy: a second start pulsed during A1; the bench SHALL see it ignored and exactly one done pulse.
